count_threshold_monitor: RTL

Downstream observer for the team's parameterised up-counter. It samples the counter's `out_data` every cycle and detects when the value reaches a programmable threshold, with optional detection of wrap or reload. Each event is timestamped and queued in a small FIFO, then presented on a valid/ready stream to software-facing logic.

---
 rtl/count_mon_pkg.sv | 20 ++
 rtl/count_threshold_monitor_if.sv | 32 +++
 rtl/event_fifo.sv | 50 +++++
 rtl/count_threshold_monitor.sv | 131 +++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared types for the count threshold monitor
// FSM state and event-type encodings.
package count_mon_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ARMED   = ST_ARMED,
    S_HOLDOFF = ST_HOLDOFF
  } state_t;

  typedef enum logic {
    EVT_MATCH = 1'b0,
    EVT_WRAP  = 1'b1
  } evt_type_t;

endpackage

// File: rtl/count_threshold_monitor_if.sv
// rtl/count_threshold_monitor_if.sv - event stream between monitor and consumer
// master = event source (monitor), slave = consumer.
interface count_threshold_monitor_if
  import count_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TS_WIDTH   = 16
);

  logic                  evt_valid;
  logic                  evt_ready;
  evt_type_t             evt_type;
  logic [DATA_WIDTH-1:0] evt_count;
  logic [TS_WIDTH-1:0]   evt_ts;

  modport master (
    output evt_valid,
    output evt_type,
    output evt_count,
    output evt_ts,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_type,
    input  evt_count,
    input  evt_ts,
    output evt_ready
  );

endinterface

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - synchronous event queue with push/pop/full/empty
// A push into a full queue is taken only when a pop happens in the same cycle.
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/count_threshold_monitor.sv
// rtl/count_threshold_monitor.sv - edge-qualified threshold detector with timestamped event queue
// Optional wrap/reload detection under COUNT_MON_WRAP_DETECT_EN.
module count_threshold_monitor
  import count_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] count_in,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic                  thr_wr,
  input  logic [DATA_WIDTH-1:0] thr_data,
  count_threshold_monitor_if.master evt,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [1:0]            state_o
);

  localparam int HCNT_W = $clog2(HOLDOFF + 1);
`ifdef COUNT_MON_WRAP_DETECT_EN
  localparam int EW = 1 + DATA_WIDTH + TS_WIDTH;
`else
  localparam int EW = DATA_WIDTH + TS_WIDTH;
`endif

  state_t                state_q, state_d;
  logic [HCNT_W-1:0]     hcnt_q, hcnt_d;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [TS_WIDTH-1:0]   ts_q;
  logic                  ovf_q;

  logic                  match_hit;
  logic                  push_match;
  logic                  push_evt;
  logic                  pop_evt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  drop;
  logic [EW-1:0]         wr_data;
  logic [EW-1:0]         rd_data;

  // Edge qualification: a counter parked on the threshold matches only once.
  assign match_hit  = (count_in == thr_q) && (count_in != prev_q);
  assign push_match = !disarm && (state_q == S_ARMED) && match_hit;

`ifdef COUNT_MON_WRAP_DETECT_EN
  logic wrap_hit;
  logic push_wrap;

  assign wrap_hit  = (count_in < prev_q) && ((state_q == S_ARMED) || (state_q == S_HOLDOFF));
  assign push_wrap = !disarm && wrap_hit && !push_match;
  assign push_evt  = push_match || push_wrap;
  assign wr_data   = {push_match ? EVT_MATCH : EVT_WRAP, count_in, ts_q};
  assign evt.evt_type = evt_type_t'(rd_data[EW-1]);
`else
  assign push_evt  = push_match;
  assign wr_data   = {count_in, ts_q};
  assign evt.evt_type = EVT_MATCH;
`endif

  assign pop_evt       = evt.evt_valid && evt.evt_ready;
  assign drop          = push_evt && fifo_full && !pop_evt;
  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_count = rd_data[TS_WIDTH +: DATA_WIDTH];
  assign evt.evt_ts    = rd_data[TS_WIDTH-1:0];
  assign overflow      = ovf_q;
  assign state_o       = state_q;

  event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_evt),
    .wr_data (wr_data),
    .pop     (pop_evt),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (match_hit) begin
          state_d = S_HOLDOFF;
          hcnt_d  = HCNT_W'(HOLDOFF);
        end
      end
      S_HOLDOFF: begin
        hcnt_d = hcnt_q - HCNT_W'(1);
        if (hcnt_q == HCNT_W'(1)) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
    if (disarm) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      thr_q   <= '0;
      prev_q  <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      prev_q  <= count_in;
      ts_q    <= ts_q + TS_WIDTH'(1);
      if (thr_wr) thr_q <= thr_data;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

endmodule
